// File: rtl/alu_issue_queue.sv
// Reservation station for the integer ALU: a collapsing, age-ordered queue that
// snoops the CDB for missing operands and issues the oldest ready micro-op.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [2:0]                 disp_alu_ext,
  input  logic [2:0]                 disp_funct3,
  input  logic [TAG_W-1:0]           disp_tag,
  input  logic [XLEN-1:0]            disp_rs1_data,
  input  logic [TAG_W-1:0]           disp_rs1_tag,
  input  logic                       disp_rs1_valid,
  input  logic [XLEN-1:0]            disp_rs2_data,
  input  logic [TAG_W-1:0]           disp_rs2_tag,
  input  logic                       disp_rs2_valid,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [XLEN-1:0]            cdb_data,
  input  logic                       issue_stall,
  output logic                       issue_valid,
  output logic [XLEN-1:0]            issue_op1,
  output logic [XLEN-1:0]            issue_op2,
  output logic [2:0]                 issue_alu_ext,
  output logic [2:0]                 issue_funct3,
  output logic [TAG_W-1:0]           issue_tag,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [2:0]       alu_ext;
    logic [2:0]       funct3;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  rs1_data;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs1_valid;
    logic [XLEN-1:0]  rs2_data;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs2_valid;
  } entry_t;

  entry_t           q       [DEPTH];
  entry_t           q_nxt   [DEPTH];
  entry_t           snooped [DEPTH];
  entry_t           shifted [DEPTH];
  entry_t           disp_entry;
  entry_t           sel_entry;

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_nxt;
  logic [OCC_W-1:0] wr_idx;
  logic [DEPTH-1:0] ready;
  logic             any_ready;
  logic [IDX_W-1:0] sel_idx;
  logic             issue_load;
  logic             do_issue;
  logic             do_disp;
  logic             rs1_hit;
  logic             rs2_hit;

  // disp_ready depends only on registered occupancy, never on a same-cycle issue.
  assign disp_ready = (occ_q < OCC_W'(DEPTH));
  assign occupancy  = occ_q;
  assign issue_load = !issue_valid || !issue_stall;
  assign do_issue   = issue_load && any_ready;
  assign do_disp    = disp_valid && disp_ready && !flush;
  assign wr_idx     = occ_q - OCC_W'(do_issue);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = q[i].valid && q[i].rs1_valid && q[i].rs2_valid;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    any_ready = 1'b0;
    sel_idx   = '0;
    sel_entry = '0;
    // Walk from the youngest down so the last hit is the oldest ready entry.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        any_ready = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_entry = q[i];
      end
    end
  end

  // Incoming micro-op, with a same-edge CDB bypass for each missing source.
  always_comb begin
    rs1_hit               = cdb_valid && !disp_rs1_valid && (cdb_tag == disp_rs1_tag);
    rs2_hit               = cdb_valid && !disp_rs2_valid && (cdb_tag == disp_rs2_tag);
    disp_entry            = '0;
    disp_entry.valid      = 1'b1;
    disp_entry.alu_ext    = disp_alu_ext;
    disp_entry.funct3     = disp_funct3;
    disp_entry.tag        = disp_tag;
    disp_entry.rs1_tag    = disp_rs1_tag;
    disp_entry.rs1_data   = rs1_hit ? cdb_data : disp_rs1_data;
    disp_entry.rs1_valid  = disp_rs1_valid || rs1_hit;
    disp_entry.rs2_tag    = disp_rs2_tag;
    disp_entry.rs2_data   = rs2_hit ? cdb_data : disp_rs2_data;
    disp_entry.rs2_valid  = disp_rs2_valid || rs2_hit;
  end

  // Resident entries capture a broadcast value for any source still waiting on it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      snooped[i] = q[i];
      if (q[i].valid && cdb_valid) begin
        if (!q[i].rs1_valid && (q[i].rs1_tag == cdb_tag)) begin
          snooped[i].rs1_data  = cdb_data;
          snooped[i].rs1_valid = 1'b1;
        end
        if (!q[i].rs2_valid && (q[i].rs2_tag == cdb_tag)) begin
          snooped[i].rs2_data  = cdb_data;
          snooped[i].rs2_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = snooped[i + 1];
    end
    shifted[DEPTH-1] = '0;
  end

  // Collapse over the issued slot, then append the dispatched op behind the survivors.
  always_comb begin
    occ_nxt = occ_q + OCC_W'(do_disp) - OCC_W'(do_issue);
    for (int i = 0; i < DEPTH; i++) begin
      if (do_issue && (i >= int'(sel_idx))) begin
        q_nxt[i] = shifted[i];
      end else begin
        q_nxt[i] = snooped[i];
      end
      if (do_disp && (i == int'(wr_idx))) begin
        q_nxt[i] = disp_entry;
      end
    end
    if (flush) begin
      occ_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_nxt[i] = '0;
      end
    end
  end

  // NOTE: the entry array is a handful of flops, not a RAM, so it is reset in full
  // rather than only its valid bits; nothing downstream ever sees stale payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
      occ_q <= occ_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= q_nxt[i];
      end
    end
  end

  // Issue register feeding the ALU; holds while its result cannot be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid   <= 1'b0;
      issue_op1     <= '0;
      issue_op2     <= '0;
      issue_alu_ext <= '0;
      issue_funct3  <= '0;
      issue_tag     <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (issue_load) begin
      issue_valid <= any_ready;
      if (any_ready) begin
        issue_op1     <= sel_entry.rs1_data;
        issue_op2     <= sel_entry.rs2_data;
        issue_alu_ext <= sel_entry.alu_ext;
        issue_funct3  <= sel_entry.funct3;
        issue_tag     <= sel_entry.tag;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue (DEPTH=4, TAG_W=6, XLEN=32).
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [2:0]  disp_alu_ext;
  logic [2:0]  disp_funct3;
  logic [5:0]  disp_tag;
  logic [31:0] disp_rs1_data;
  logic [5:0]  disp_rs1_tag;
  logic        disp_rs1_valid;
  logic [31:0] disp_rs2_data;
  logic [5:0]  disp_rs2_tag;
  logic        disp_rs2_valid;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_stall;
  logic        issue_valid;
  logic [31:0] issue_op1;
  logic [31:0] issue_op2;
  logic [2:0]  issue_alu_ext;
  logic [2:0]  issue_funct3;
  logic [5:0]  issue_tag;
  logic [2:0]  occupancy;

  int checks = 0;
  int passes = 0;

  alu_issue_queue #(.DEPTH(4), .TAG_W(6), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_alu_ext(disp_alu_ext), .disp_funct3(disp_funct3), .disp_tag(disp_tag),
    .disp_rs1_data(disp_rs1_data), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_valid(disp_rs1_valid),
    .disp_rs2_data(disp_rs2_data), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_valid(disp_rs2_valid),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_stall(issue_stall), .issue_valid(issue_valid),
    .issue_op1(issue_op1), .issue_op2(issue_op2),
    .issue_alu_ext(issue_alu_ext), .issue_funct3(issue_funct3),
    .issue_tag(issue_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [2:0] ext, input logic [2:0] f3, input logic [5:0] tag,
                      input logic [31:0] d1, input logic [5:0] t1, input logic v1,
                      input logic [31:0] d2, input logic [5:0] t2, input logic v2);
    disp_valid     = 1'b1;
    disp_alu_ext   = ext;
    disp_funct3    = f3;
    disp_tag       = tag;
    disp_rs1_data  = d1;
    disp_rs1_tag   = t1;
    disp_rs1_valid = v1;
    disp_rs2_data  = d2;
    disp_rs2_tag   = t2;
    disp_rs2_valid = v2;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
  endtask

  task automatic bcast(input logic [5:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_stall = 1'b0;
    disp(3'd0, 3'd0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
    cdb_tag = '0; cdb_data = '0;
    idle();
    #12;
    check("reset_issue_valid", issue_valid, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_op1", issue_op1, 0);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", disp_ready, 1);

    // Single fully-ready op: visible one edge after dispatch.
    disp(3'd0, 3'd0, 6'd3, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1);
    tick(); idle();
    check("t1_occ_after_disp", occupancy, 1);
    check("t1_not_yet_issued", issue_valid, 0);
    tick();
    check("t1_issue_valid", issue_valid, 1);
    check("t1_op1", issue_op1, 5);
    check("t1_op2", issue_op2, 7);
    check("t1_tag", issue_tag, 3);
    check("t1_occ_drained", occupancy, 0);
    tick();
    check("t1_issue_empty", issue_valid, 0);

    // Younger ready op overtakes older waiting op; CDB wakes the older one.
    disp(3'd1, 3'd2, 6'd1, 32'h1, 6'd0, 1'b1, 32'h0, 6'd9, 1'b0);
    tick();
    disp(3'd2, 3'd5, 6'd2, 32'h2, 6'd0, 1'b1, 32'h3, 6'd0, 1'b1);
    tick(); idle();
    check("t2_occ_two", occupancy, 2);
    bcast(6'd9, 32'h10);
    tick(); idle();
    check("t2_first_tag", issue_tag, 2);
    check("t2_first_ext", issue_alu_ext, 2);
    check("t2_first_f3", issue_funct3, 5);
    check("t2_occ_one", occupancy, 1);
    tick();
    check("t2_second_valid", issue_valid, 1);
    check("t2_second_tag", issue_tag, 1);
    check("t2_second_op1", issue_op1, 1);
    check("t2_second_op2", issue_op2, 32'h10);
    check("t2_occ_zero", occupancy, 0);
    tick();

    // Dispatch bypass: rs1 captured from the CDB on the dispatch edge.
    disp(3'd0, 3'd0, 6'd5, 32'h0, 6'd4, 1'b0, 32'h22, 6'd0, 1'b1);
    bcast(6'd4, 32'hAB);
    tick(); idle();
    check("t3_occ", occupancy, 1);
    tick();
    check("t3_valid", issue_valid, 1);
    check("t3_tag", issue_tag, 5);
    check("t3_op1_bypass", issue_op1, 32'hAB);
    check("t3_op2", issue_op2, 32'h22);
    tick();
    check("t3_drained", issue_valid, 0);

    // Stall: issue register holds, queue fills, disp_ready drops.
    disp(3'd0, 3'd0, 6'd6, 32'h11, 6'd0, 1'b1, 32'h12, 6'd0, 1'b1);
    tick(); idle();
    issue_stall = 1'b1;
    tick();
    check("t4_held_valid", issue_valid, 1);
    check("t4_held_tag", issue_tag, 6);
    for (int i = 0; i < 4; i++) begin
      disp(3'd0, 3'd0, 6'(10 + i), 32'(32'h100 + 10 + i), 6'd0, 1'b1, 32'h0, 6'd20, 1'b0);
      tick();
    end
    check("t4_full_occ", occupancy, 4);
    check("t4_full_ready", disp_ready, 0);
    check("t4_stall_tag", issue_tag, 6);
    check("t4_stall_op1", issue_op1, 32'h11);
    // Full queue rejects dispatch; a tag differing only in its MSB must not wake anyone.
    disp(3'd0, 3'd0, 6'd14, 32'h77, 6'd0, 1'b1, 32'h78, 6'd0, 1'b1);
    bcast(6'h34, 32'h66);
    tick(); idle();
    check("t4_reject_occ", occupancy, 4);
    bcast(6'd20, 32'h55);
    tick(); idle();
    check("t4_stall_still_tag", issue_tag, 6);
    check("t4_stall_still_valid", issue_valid, 1);
    issue_stall = 1'b0;
    tick();
    check("t4_r1_tag", issue_tag, 10);
    check("t4_r1_op1", issue_op1, 32'h10A);
    check("t4_r1_op2", issue_op2, 32'h55);
    check("t4_r1_occ", occupancy, 3);
    check("t4_r1_ready", disp_ready, 1);
    // Issue and dispatch on the same edge: occupancy holds, new op goes last.
    disp(3'd3, 3'd4, 6'd14, 32'h77, 6'd0, 1'b1, 32'h78, 6'd0, 1'b1);
    tick(); idle();
    check("t4_r2_tag", issue_tag, 11);
    check("t4_r2_occ", occupancy, 3);
    tick();
    check("t4_r3_tag", issue_tag, 12);
    check("t4_r3_occ", occupancy, 2);
    tick();
    check("t4_r4_tag", issue_tag, 13);
    tick();
    check("t4_r5_tag", issue_tag, 14);
    check("t4_r5_op1", issue_op1, 32'h77);
    check("t4_r5_ext", issue_alu_ext, 3);
    check("t4_r5_occ", occupancy, 0);
    tick();
    check("t4_empty", issue_valid, 0);

    // Flush with a valid issue register and three resident entries.
    disp(3'd0, 3'd0, 6'd21, 32'h0, 6'd30, 1'b0, 32'h1, 6'd0, 1'b1);
    tick();
    disp(3'd0, 3'd0, 6'd22, 32'h0, 6'd30, 1'b0, 32'h1, 6'd0, 1'b1);
    tick();
    disp(3'd0, 3'd0, 6'd23, 32'h5, 6'd0, 1'b1, 32'h6, 6'd0, 1'b1);
    tick(); idle();
    issue_stall = 1'b1;
    tick();
    check("t5_pre_valid", issue_valid, 1);
    check("t5_pre_tag", issue_tag, 23);
    disp(3'd0, 3'd0, 6'd24, 32'h0, 6'd30, 1'b0, 32'h1, 6'd0, 1'b1);
    tick();
    check("t5_pre_occ", occupancy, 3);
    disp(3'd0, 3'd0, 6'd25, 32'h9, 6'd0, 1'b1, 32'h9, 6'd0, 1'b1);
    flush = 1'b1;
    tick(); idle();
    flush = 1'b0;
    issue_stall = 1'b0;
    check("t5_flush_occ", occupancy, 0);
    check("t5_flush_valid", issue_valid, 0);
    tick();
    check("t5_dropped_valid", issue_valid, 0);
    check("t5_dropped_occ", occupancy, 0);

    // Asynchronous reset mid-cycle with live state.
    disp(3'd0, 3'd0, 6'd39, 32'h1, 6'd0, 1'b1, 32'h2, 6'd0, 1'b1);
    tick();
    disp(3'd0, 3'd0, 6'd40, 32'h0, 6'd50, 1'b0, 32'h1, 6'd0, 1'b1);
    tick();
    check("t6_issue_39", issue_tag, 39);
    check("t6_occ_one", occupancy, 1);
    disp(3'd0, 3'd0, 6'd41, 32'h0, 6'd50, 1'b0, 32'h1, 6'd0, 1'b1);
    issue_stall = 1'b1;
    tick(); idle();
    check("t6_occ_two", occupancy, 2);
    check("t6_valid_held", issue_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", issue_valid, 0);
    check("t6_rst_occ", occupancy, 0);
    check("t6_rst_op1", issue_op1, 0);
    check("t6_rst_tag", issue_tag, 0);
    check("t6_rst_ready", disp_ready, 1);
    #1;
    rst_n = 1'b1;
    issue_stall = 1'b0;
    tick();
    check("t6_post_valid", issue_valid, 0);
    check("t6_post_occ", occupancy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
